// File: rtl/output_writeback_if.sv
// Write-back stage bus bundle: result frame in, register file bank out.
interface output_writeback_if #(
    parameter int unsigned DATA_WIDTH     = 4,
    parameter int unsigned REGS           = 64,
    parameter int unsigned INPUTS         = 4,
    parameter int unsigned INPUTS_PER_BUS = 4
);
    localparam int unsigned BUS_W  = INPUTS_PER_BUS * DATA_WIDTH;
    localparam int unsigned LANES  = INPUTS * INPUTS_PER_BUS;
    localparam int unsigned DEST_W = $clog2(REGS);

    logic                         wStart;
    logic [BUS_W-1:0]             r0;
    logic [BUS_W-1:0]             r1;
    logic [BUS_W-1:0]             r2;
    logic [BUS_W-1:0]             r3;
    logic [LANES-1:0]             wWriteEn;
    logic [LANES*DEST_W-1:0]      wDest;
    logic                         wBusy;
    logic                         wDone;
    logic [REGS*DATA_WIDTH-1:0]   wRegs;

    modport master (
        output wStart, r0, r1, r2, r3, wWriteEn, wDest,
        input  wBusy, wDone, wRegs
    );

    modport slave (
        input  wStart, r0, r1, r2, r3, wWriteEn, wDest,
        output wBusy, wDone, wRegs
    );
endinterface

// File: rtl/output_writeback_block.sv
// Write-back stage: stages one 16-lane result frame, then commits it into the
// register file WRITE_PORTS lanes per cycle, highest lane winning on conflicts.
module output_writeback_block #(
    parameter int unsigned DATA_WIDTH     = 4,
    parameter int unsigned REGS           = 64,
    parameter int unsigned INPUTS         = 4,
    parameter int unsigned INPUTS_PER_BUS = 4,
    parameter int unsigned WRITE_PORTS    = 4
) (
    input  logic                clk,
    input  logic                rst,
    output_writeback_if.slave   bus
);
    localparam int unsigned LANES  = INPUTS * INPUTS_PER_BUS;
    localparam int unsigned GROUPS = LANES / WRITE_PORTS;
    localparam int unsigned DEST_W = $clog2(REGS);
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                                state;
    state_t                                stateNext;
    logic [G_W-1:0]                        g;
    logic [G_W-1:0]                        gNext;
    logic                                  busyReg;
    logic                                  busyNext;
    logic                                  doneReg;
    logic                                  doneNext;
    logic                                  capture;

    logic [LANES-1:0][DATA_WIDTH-1:0]      laneData;
    logic [LANES-1:0][DEST_W-1:0]          laneDest;
    logic [LANES-1:0][DATA_WIDTH-1:0]      stageData;
    logic [LANES-1:0][DEST_W-1:0]          stageDest;
    logic [LANES-1:0]                      stageEn;
    logic [REGS-1:0][DATA_WIDTH-1:0]       regFile;
    logic [REGS-1:0][DATA_WIDTH-1:0]       regNext;
    logic [LANE_W-1:0]                     lane;

    // Global lane 4b+k is lane k of bus b, so bus 0 sits in the low bits.
    assign laneData = {bus.r3, bus.r2, bus.r1, bus.r0};
    assign laneDest = bus.wDest;

    // Frame sequencing: capture in IDLE, walk the groups in WRITE.
    always_comb begin
        stateNext = state;
        gNext     = g;
        busyNext  = 1'b0;
        doneNext  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.wStart) begin
                    capture   = 1'b1;
                    gNext     = '0;
                    busyNext  = 1'b1;
                    stateNext = WRITE;
                end
            end
            WRITE: begin
                if (g == G_W'(GROUPS - 1)) begin
                    gNext     = '0;
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    gNext    = g + G_W'(1);
                    busyNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Ascending lane order makes the highest enabled lane the last writer.
    always_comb begin
        regNext = regFile;
        lane    = '0;
        if (state == WRITE) begin
            for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
                lane = LANE_W'(32'(g) * WRITE_PORTS + p);
                if (stageEn[lane]) begin
                    regNext[stageDest[lane]] = stageData[lane];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            g       <= '0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            state   <= stateNext;
            g       <= gNext;
            busyReg <= busyNext;
            doneReg <= doneNext;
        end
    end

    // Staging holds the frame so inputs may change freely during WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stageData <= '0;
            stageDest <= '0;
            stageEn   <= '0;
            regFile   <= '0;
        end else begin
            regFile <= regNext;
            if (capture) begin
                stageData <= laneData;
                stageDest <= laneDest;
                stageEn   <= bus.wWriteEn;
            end
        end
    end

    assign bus.wBusy = busyReg;
    assign bus.wDone = doneReg;
    assign bus.wRegs = regFile;
endmodule

// File: tb/tb_output_writeback_block.sv
// Scoreboard bench for output_writeback_block: frame-level register file model,
// expected results queued at issue and checked by a monitor on each wDone.
module tb_output_writeback_block;
    localparam int unsigned RW     = 256;
    localparam int unsigned LANES  = 16;
    localparam int unsigned DEST_W = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    output_writeback_if bus ();

    output_writeback_block dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nChecks = 0;
    int nFails  = 0;
    logic [RW-1:0] modelRegs;
    logic [RW-1:0] expQ[$];

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic randInputs();
        bus.r0       = 16'($urandom);
        bus.r1       = 16'($urandom);
        bus.r2       = 16'($urandom);
        bus.r3       = 16'($urandom);
        bus.wWriteEn = 16'($urandom);
        bus.wDest    = {$urandom, $urandom, $urandom};
    endtask

    function automatic logic [95:0] randDest(input bit narrow);
        logic [95:0] d = '0;
        for (int i = 0; i < int'(LANES); i++)
            d[i*DEST_W +: DEST_W] = 6'($urandom_range(0, narrow ? 7 : 63));
        return d;
    endfunction

    // Issues one frame from just after a falling edge; returns in the wDone cycle.
    task automatic sendFrame(input logic [15:0] a0, input logic [15:0] a1,
                             input logic [15:0] a2, input logic [15:0] a3,
                             input logic [15:0] en, input logic [95:0] dst,
                             input bit intrude);
        logic [63:0]   lanes = {a3, a2, a1, a0};
        logic [RW-1:0] cur   = modelRegs;
        logic [RW-1:0] expG[4];
        int            l;
        int            d;
        for (int grp = 0; grp < 4; grp++) begin
            for (int p = 0; p < 4; p++) begin
                l = grp * 4 + p;
                d = int'(dst[l*DEST_W +: DEST_W]);
                if (en[l]) cur[d*4 +: 4] = lanes[l*4 +: 4];
            end
            expG[grp] = cur;
        end
        modelRegs = cur;
        expQ.push_back(cur);

        bus.r0 = a0; bus.r1 = a1; bus.r2 = a2; bus.r3 = a3;
        bus.wWriteEn = en;
        bus.wDest    = dst;
        bus.wStart   = 1'b1;
        @(negedge clk);
        bus.wStart = 1'b0;
        randInputs();
        check("busy_after_start", RW'(bus.wBusy), RW'(1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("group%0d_regs", k), bus.wRegs, expG[k]);
            check($sformatf("busy_group%0d", k), RW'(bus.wBusy), RW'(1));
            if (intrude && k == 0) begin
                bus.r0 = ~a0; bus.r1 = ~a1; bus.r2 = ~a2; bus.r3 = ~a3;
                bus.wWriteEn = '1;
                bus.wDest    = '0;
                bus.wStart   = 1'b1;
            end else begin
                bus.wStart = 1'b0;
            end
        end
        @(negedge clk);
        check("busy_low_at_done", RW'(bus.wBusy), RW'(0));
        check("done_pulse", RW'(bus.wDone), RW'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every wDone must match the oldest outstanding frame.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("busy_done_exclusive", RW'(bus.wBusy & bus.wDone), RW'(0));
                if (bus.wDone) begin
                    if (expQ.size() == 0) begin
                        nChecks++;
                        nFails++;
                        $display("FAIL unexpected_done: got wDone=1 expected no pending frame");
                    end else begin
                        check("frame_result", bus.wRegs, expQ.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [95:0] dst;
        logic [15:0] b0, b1, b2, b3;
        bit          narrow;

        rst          = 1'b1;
        bus.wStart   = 1'b0;
        bus.r0 = '0; bus.r1 = '0; bus.r2 = '0; bus.r3 = '0;
        bus.wWriteEn = '0;
        bus.wDest    = '0;
        modelRegs    = '0;
        idle(2);
        check("reset_regs", bus.wRegs, '0);
        check("reset_busy", RW'(bus.wBusy), RW'(0));
        check("reset_done", RW'(bus.wDone), RW'(0));
        rst = 1'b0;
        idle(1);

        // Full frame, lane i to entry i.
        dst = '0;
        for (int i = 0; i < int'(LANES); i++) dst[i*DEST_W +: DEST_W] = 6'(i);
        sendFrame(16'h3210, 16'h7654, 16'hba98, 16'hfedc, 16'hffff, dst, 1'b0);
        check("full_frame_low64", RW'(bus.wRegs[63:0]), RW'(64'hfedcba9876543210));
        idle(2);

        // Asynchronous reset between edges clears everything immediately.
        #2 rst = 1'b1;
        #1;
        check("async_reset_regs", bus.wRegs, '0);
        check("async_reset_busy", RW'(bus.wBusy), RW'(0));
        check("async_reset_done", RW'(bus.wDone), RW'(0));
        modelRegs = '0;
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Background content, then conflicting destinations.
        sendFrame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'hffff, randDest(1'b0), 1'b0);
        dst = randDest(1'b0);
        dst[2*DEST_W +: DEST_W] = 6'h10;
        dst[9*DEST_W +: DEST_W] = 6'h10;
        dst[3*DEST_W +: DEST_W] = 6'h20;
        dst[1*DEST_W +: DEST_W] = 6'h20;
        sendFrame(16'h1570, 16'h0000, 16'h00a0, 16'h0000, 16'h020e, dst, 1'b0);
        check("conflict_entry16", RW'(bus.wRegs[16*4 +: 4]), RW'(4'ha));
        check("conflict_entry32", RW'(bus.wRegs[32*4 +: 4]), RW'(4'h1));
        idle(1);

        // wStart during WRITE is ignored and not queued.
        sendFrame(16'h1234, 16'h5678, 16'h9abc, 16'hdef0, 16'hffff, randDest(1'b0), 1'b1);
        idle(6);

        // Reset after E2 abandons the frame without a wDone pulse.
        bus.r0 = 16'($urandom); bus.r1 = 16'($urandom);
        bus.r2 = 16'($urandom); bus.r3 = 16'($urandom);
        bus.wWriteEn = '1;
        bus.wDest    = randDest(1'b0);
        bus.wStart   = 1'b1;
        @(negedge clk);
        bus.wStart = 1'b0;
        idle(2);
        #1 rst = 1'b1;
        #1;
        check("midframe_reset_regs", bus.wRegs, '0);
        check("midframe_reset_busy", RW'(bus.wBusy), RW'(0));
        check("midframe_reset_done", RW'(bus.wDone), RW'(0));
        modelRegs = '0;
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(6);
        sendFrame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), randDest(1'b0), 1'b0);

        // Zero mask followed back-to-back by a normal frame.
        sendFrame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'h0000, randDest(1'b0), 1'b0);
        sendFrame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'hffff, randDest(1'b0), 1'b0);

        // Randomized frames with occasional narrow destinations and intrusions.
        for (int n = 0; n < 30; n++) begin
            b0 = 16'($urandom); b1 = 16'($urandom);
            b2 = 16'($urandom); b3 = 16'($urandom);
            narrow = ($urandom_range(0, 1) == 1);
            sendFrame(b0, b1, b2, b3, 16'($urandom), randDest(narrow),
                      ($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 2));
        end

        idle(3);
        check("queue_drained", RW'(expQ.size()), RW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/output_writeback_block.md
# output_writeback_block

Write-back stage that closes the datapath loop. It captures one result frame of 16 lanes (four 16-bit buses of four 4-bit lanes each), then commits the enabled lanes into a 64-entry × 4-bit register file over four cycles. The register file is driven flat on `wRegs`, which is the register operand bank consumed by the input selector block.

## Interface
Parameters:
- `DATA_WIDTH`, 4, bits per lane and per register entry
- `REGS`, 64, register file depth
- `INPUTS`, 4, result buses (`r0`..`r3`)
- `INPUTS_PER_BUS`, 4, lanes per bus; total lanes L = INPUTS*INPUTS_PER_BUS = 16
- `WRITE_PORTS`, 4, lanes committed per cycle; L must be a multiple of it

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
  - `clk`  in  1  single clock, rising edge
  - `rst`  in  1  asynchronous, active-high reset
- `wStart`  in  1  frame request, sampled only in IDLE
- `r0`,`r1`,`r2`,`r3`  in  16 each  result buses; lane k of bus b = global lane 4b+k, at bits [4k+3:4k]
- `wWriteEn`  in  L (16)  per-lane write enable, bit i = lane i
- `wDest`  in  L*$clog2(REGS) (96)  per-lane destination, lane i at [6i+5:6i]
- `wBusy`  out  1  high while a frame is being committed
- `wDone`  out  1  one-cycle pulse after the final commit cycle
- `wRegs`  out  REGS*DATA_WIDTH (256)  register file; entry j at [4j+3:4j]

## Operation
- FSM states: IDLE, WRITE. Group counter `g`, range 0..L/WRITE_PORTS-1 (0..3).
- IDLE with `wStart`=1 at a clock edge:
  - Capture all lanes of r0..r3, `wWriteEn` and `wDest` into staging registers.
  - Set g=0 and go to WRITE.
- Inputs are not needed after capture. Changes to them during WRITE have no effect.
- WRITE, each edge:
  - Commit lanes g*WRITE_PORTS .. g*WRITE_PORTS+WRITE_PORTS-1.
  - Each lane with its enable set writes its staged data to `wRegs[dest]`. Disabled lanes write nothing.
  - Then g increments.
  - On the edge that commits the last group: return to IDLE and pulse `wDone`.
- Destination conflicts: when several enabled lanes target the same entry, the highest-numbered lane wins. This holds inside a group (priority logic) and across groups (later group overwrites).
- `wStart` while in WRITE is ignored. It is not queued.
- An all-zero enable mask still runs the full 4-cycle sequence and pulses `wDone`. The register file is unchanged.
- Destination indices are always in range (6 bits address all 64 entries). No clamping is needed.

## Timing
- Reset (async assertion, any time, including mid-frame):
  - `wRegs` = 0, `wBusy` = 0, `wDone` = 0, state IDLE, g = 0.
  - Staging is cleared and any partial frame is abandoned. Groups already committed stay as written until reset clears the file.
- `wStart` sampled at edge E0: `wBusy` = 1 from E0 to E4.
- Group g commits at edge E(g+1), and its writes are visible on `wRegs` immediately after that edge.
- After E4:
  - `wBusy` = 0 and `wDone` = 1 for exactly one cycle.
  - A new `wStart` present during that cycle is accepted at E5 (back-to-back frames, 4 busy cycles plus 1 idle cycle).
- `wBusy` and `wDone` are registered outputs. They are never both high.
- Frame latency, start edge to final data visible: 4 cycles.

## Test plan
- Reset: assert `rst` asynchronously between edges.
  - -> `wRegs`=0, `wBusy`=0 and `wDone`=0 immediately, without waiting for a clock edge.
- Full frame: r0=16'h3210, r1=16'h7654, r2=16'hba98, r3=16'hfedc, all enables=1, lane i dest = i.
  - -> After E1, `wRegs[15:0]`=16'h3210.
  - -> After E4, `wRegs[63:0]`=64'hfedcba9876543210 and `wDone` pulses once.
- Conflict: lane 2 = 4'h5 and lane 9 = 4'hA, both dest 6'h10; lane 3 = 4'h1 and lane 1 = 4'h7, both dest 6'h20; only these four lanes enabled.
  - -> Entry 16 = A and entry 32 = 1.
  - -> All other entries unchanged.
- Start while busy: pulse `wStart` at E2 with different data, all lanes dest 0.
  - -> Ignored; entry 0 keeps the first frame's value.
  - -> `wDone` pulses only once, after E4.
- Reset mid-frame: assert `rst` after E2.
  - -> `wRegs` is all zero, `wBusy`=0, and no `wDone` pulse.
  - -> The next `wStart` runs a clean 4-cycle frame.
- Zero mask: `wWriteEn`=0 with random data and destinations.
  - -> `wRegs` unchanged, `wBusy` high for 4 cycles, `wDone` pulses once.
  - -> A back-to-back frame started in the `wDone` cycle commits normally.
